// File: rtl/i2c_receiver.sv
// rtl/i2c_receiver.sv - I2C target that ACKs its address, collects DATA_W-bit writes and serves reads.
// Optional macro I2C_GENERAL_CALL_EN: ACK address 7'h00 for writes (general call).
module i2c_receiver #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        I2C_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    input  logic              SCL,
    input  logic              SDA_IN,
    output logic              SDA_OUT,
    output logic              SDA_OE,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              WR_STB,
    output logic              BUSY
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t            state_q;
    logic              scl_q, sda_q;
    logic [3:0]        bit_cnt_q;
    logic [CW-1:0]     byte_cnt_q;
    logic [6:0]        shift_q;
    logic              rnw_q;
    logic [DATA_W-1:0] word_q, tx_q, wr_data_q;
    logic              sda_out_q, sda_oe_q, wr_stb_q, busy_q;

    logic              rise, fall, start_det, stop_det, addr_hit;
    logic [7:0]        byte_d;
    logic [DATA_W-1:0] word_d;

    assign rise      = SCL & ~scl_q;
    assign fall      = ~SCL & scl_q;
    assign start_det = SCL & scl_q & sda_q & ~SDA_IN;
    assign stop_det  = SCL & scl_q & ~sda_q & SDA_IN;
    assign byte_d    = {shift_q, SDA_IN};
    assign word_d    = (word_q << 8) | DATA_W'(byte_d);

    always_comb begin
`ifdef I2C_GENERAL_CALL_EN
        if (byte_d[7:1] == 7'h00)
            addr_hit = ~byte_d[0];
        else
            addr_hit = (byte_d[7:1] == I2C_ADDR);
`else
        addr_hit = (byte_d[7:1] == I2C_ADDR);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            rnw_q      <= 1'b0;
            word_q     <= '0;
            tx_q       <= '0;
            wr_data_q  <= '0;
            sda_out_q  <= 1'b1;
            sda_oe_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_q    <= SCL;
            sda_q    <= SDA_IN;
            wr_stb_q <= 1'b0;
            if (start_det) begin
                state_q    <= S_ADDR;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                sda_oe_q   <= 1'b0;
                sda_out_q  <= 1'b1;
                busy_q     <= 1'b1;
            end else if (stop_det) begin
                state_q   <= S_IDLE;
                sda_oe_q  <= 1'b0;
                sda_out_q <= 1'b1;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (rise && bit_cnt_q < 4'd8) begin
                            shift_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rnw_q <= byte_d[0];
                                if (!addr_hit)
                                    state_q <= S_WAIT_STOP;
                                if (byte_d[0])
                                    tx_q <= RD_DATA;
                            end
                        end else if (fall && bit_cnt_q == 4'd8) begin
                            sda_oe_q  <= 1'b1;
                            sda_out_q <= 1'b0;
                            state_q   <= S_ADDR_ACK;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (fall) begin
                            if (rnw_q) begin
                                sda_oe_q  <= 1'b1;
                                sda_out_q <= tx_q[DATA_W-1];
                                tx_q      <= tx_q << 1;
                                bit_cnt_q <= 4'd1;
                                state_q   <= S_RD_BYTE;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                sda_out_q <= 1'b1;
                                bit_cnt_q <= '0;
                                state_q   <= S_WR_BYTE;
                            end
                        end
                    end
                    S_WR_BYTE: begin
                        if (rise && bit_cnt_q < 4'd8) begin
                            shift_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                // Bytes beyond the word are refused by withholding the ACK.
                                if (byte_cnt_q == CW'(NB)) begin
                                    state_q <= S_WAIT_STOP;
                                end else begin
                                    word_q <= word_d;
                                    if (byte_cnt_q == CW'(NB - 1)) begin
                                        wr_data_q <= word_d;
                                        wr_stb_q  <= 1'b1;
                                    end
                                end
                            end
                        end else if (fall && bit_cnt_q == 4'd8) begin
                            sda_oe_q   <= 1'b1;
                            sda_out_q  <= 1'b0;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: begin
                        if (fall) begin
                            sda_oe_q  <= 1'b0;
                            sda_out_q <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= S_WR_BYTE;
                        end
                    end
                    S_RD_BYTE: begin
                        if (fall) begin
                            if (bit_cnt_q < 4'd8) begin
                                sda_out_q <= tx_q[DATA_W-1];
                                tx_q      <= tx_q << 1;
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end else begin
                                sda_oe_q   <= 1'b0;
                                sda_out_q  <= 1'b1;
                                bit_cnt_q  <= '0;
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                                state_q    <= S_RD_ACK;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        // bit_cnt_q doubles as "master ACKed, more to send" flag here.
                        if (rise) begin
                            if (SDA_IN || byte_cnt_q == CW'(NB))
                                state_q <= S_WAIT_STOP;
                            else
                                bit_cnt_q <= 4'd1;
                        end else if (fall && bit_cnt_q == 4'd1) begin
                            sda_oe_q  <= 1'b1;
                            sda_out_q <= tx_q[DATA_W-1];
                            tx_q      <= tx_q << 1;
                            state_q   <= S_RD_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA_OUT = sda_out_q;
    assign SDA_OE  = sda_oe_q;
    assign WR_DATA = wr_data_q;
    assign WR_STB  = wr_stb_q;
    assign BUSY    = busy_q;
endmodule

// File: tb/tb_i2c_receiver.sv
// tb/tb_i2c_receiver.sv - self-checking bench for i2c_receiver with a bit-banged master.
module tb_i2c_receiver;
    localparam int DATA_W = 16;
    localparam int NB     = DATA_W / 8;
    localparam int H      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        I2C_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic              SCL, SDA_IN;
    logic              SDA_OUT, SDA_OE, WR_STB, BUSY;
    logic [DATA_W-1:0] WR_DATA;

    always #5 clk = ~clk;

    i2c_receiver #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .I2C_ADDR(I2C_ADDR), .RD_DATA(RD_DATA),
        .SCL(SCL), .SDA_IN(SDA_IN), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE),
        .WR_DATA(WR_DATA), .WR_STB(WR_STB), .BUSY(BUSY)
    );

    typedef struct {
        logic [6:0]  tgt;
        logic [7:0]  ab;
        int          n;
        logic [31:0] bytes;
        logic        e_aack;
        logic [3:0]  e_back;
        logic [15:0] e_wr;
        int          e_stb;
    } wvec_t;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int stb_run = 0;
    bit stb_long = 0;
    bit oe_seen = 0;
    logic [15:0] model_wr;

    always @(negedge clk) begin
        if (WR_STB) begin
            stb_cnt++;
            stb_run++;
            if (stb_run > 1) stb_long = 1;
        end else begin
            stb_run = 0;
        end
        if (SDA_OE) oe_seen = 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic oe, output logic o);
        SDA_IN = b;
        wait_n(H);
        SCL = 1'b1;
        wait_n(H);
        oe = SDA_OE;
        o  = SDA_OUT;
        SCL = 1'b0;
    endtask

    task automatic do_start();
        if (SCL == 1'b0) begin
            SDA_IN = 1'b1;
            wait_n(H);
            SCL = 1'b1;
            wait_n(H);
        end
        SDA_IN = 1'b0;
        wait_n(H);
        chk("busy_after_start", BUSY, 1);
        SCL = 1'b0;
    endtask

    task automatic do_stop();
        SDA_IN = 1'b0;
        wait_n(H);
        SCL = 1'b1;
        wait_n(H);
        chk("busy_before_stop", BUSY, 1);
        SDA_IN = 1'b1;
        wait_n(1);
        chk("busy_1cyc_after_stop", BUSY, 0);
        chk("oe_after_stop", SDA_OE, 0);
        wait_n(H);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic oe, o;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], oe, o);
        clk_bit(1'b1, oe, o);
        ack = oe & ~o;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] v);
        logic oe, o;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, oe, o);
            chk("rd_bit_oe", oe, 1);
            v[i] = o;
        end
        clk_bit(mack, oe, o);
        chk("rd_mack_slot_oe", oe, 0);
    endtask

    task automatic run_write(input wvec_t v);
        int   stb0;
        logic ack;
        stb0     = stb_cnt;
        oe_seen  = 0;
        stb_long = 0;
        I2C_ADDR = v.tgt;
        do_start();
        wr_byte(v.ab, ack);
        chk("addr_ack", ack, v.e_aack);
        for (int k = 0; k < v.n; k++) begin
            wr_byte(v.bytes[31-8*k -: 8], ack);
            chk("data_ack", ack, v.e_back[k]);
        end
        do_stop();
        chk("wr_data", WR_DATA, v.e_wr);
        chk("wr_stb_count", stb_cnt - stb0, v.e_stb);
        chk("wr_stb_width", stb_long, 0);
        if (!v.e_aack) chk("oe_never_on_mismatch", oe_seen, 0);
    endtask

    function automatic logic model_hit(input logic [6:0] tgt, input logic [7:0] ab);
`ifdef I2C_GENERAL_CALL_EN
        if (ab[7:1] == 7'h00) return ~ab[0];
`endif
        return ab[7:1] == tgt;
    endfunction

    wvec_t tab[7];
    wvec_t rv;
    logic        ack, mack;
    logic [7:0]  got;
    logic [15:0] rsnap;
    int          stb_before, nb;

    initial begin
        rst = 1'b1; SCL = 1'b1; SDA_IN = 1'b1; I2C_ADDR = 7'h2B; RD_DATA = '0;
        wait_n(3);
        chk("rst_sda_out", SDA_OUT, 1);
        chk("rst_sda_oe", SDA_OE, 0);
        chk("rst_wr_data", WR_DATA, 0);
        chk("rst_wr_stb", WR_STB, 0);
        chk("rst_busy", BUSY, 0);
        rst = 1'b0;
        wait_n(3);

        tab[0] = '{7'h2B, 8'h56, 2, 32'h5A3C0000, 1'b1, 4'b0011, 16'h5A3C, 1};
        tab[1] = '{7'h2B, 8'h54, 2, 32'h12340000, 1'b0, 4'b0000, 16'h5A3C, 0};
        tab[2] = '{7'h2B, 8'h56, 1, 32'h11000000, 1'b1, 4'b0001, 16'h5A3C, 0};
        tab[3] = '{7'h2B, 8'h56, 3, 32'h12345600, 1'b1, 4'b0011, 16'h1234, 1};
        tab[4] = '{7'h11, 8'h22, 2, 32'hA50F0000, 1'b1, 4'b0011, 16'hA50F, 1};
`ifdef I2C_GENERAL_CALL_EN
        tab[5] = '{7'h2B, 8'h00, 2, 32'hFFFF0000, 1'b1, 4'b0011, 16'hFFFF, 1};
`else
        tab[5] = '{7'h2B, 8'h00, 2, 32'hFFFF0000, 1'b0, 4'b0000, 16'hA50F, 0};
`endif
        tab[6] = '{7'h7F, 8'hFE, 2, 32'h00010000, 1'b1, 4'b0011, 16'h0001, 1};
        for (int i = 0; i < 7; i++) run_write(tab[i]);
        model_wr = tab[6].e_wr;

        // Read BEEF: ACK first byte, NACK second; RD_DATA changed after address ACK
        I2C_ADDR = 7'h2B; RD_DATA = 16'hBEEF;
        do_start();
        wr_byte(8'h57, ack);
        chk("rd_addr_ack", ack, 1);
        RD_DATA = 16'h0000;
        rd_byte(1'b0, got);
        chk("rd_byte1", got, 8'hBE);
        rd_byte(1'b1, got);
        chk("rd_byte2", got, 8'hEF);
        chk("rd_release_after_nack", SDA_OE, 0);
        do_stop();

        // Write then repeated START into a read
        stb_before = stb_cnt;
        do_start();
        wr_byte(8'h56, ack);
        chk("rs_addr_ack", ack, 1);
        wr_byte(8'hAA, ack);
        chk("rs_data_ack", ack, 1);
        RD_DATA = 16'h1357;
        do_start();
        wr_byte(8'h57, ack);
        chk("rs_rd_addr_ack", ack, 1);
        rd_byte(1'b0, got);
        chk("rs_rd_byte1", got, 8'h13);
        rd_byte(1'b1, got);
        chk("rs_rd_byte2", got, 8'h57);
        do_stop();
        chk("rs_wr_data_kept", WR_DATA, model_wr);
        chk("rs_no_stb", stb_cnt - stb_before, 0);

        // Reset in the middle of a read byte
        RD_DATA = 16'hC3A5;
        do_start();
        wr_byte(8'h57, ack);
        chk("mr_addr_ack", ack, 1);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, ack, mack);
        chk("mr_oe_before_rst", SDA_OE, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_oe_async", SDA_OE, 0);
        chk("mr_out_async", SDA_OUT, 1);
        chk("mr_busy_async", BUSY, 0);
        chk("mr_wr_data_async", WR_DATA, 0);
        @(negedge clk);
        rst = 1'b0;
        SDA_IN = 1'b1;
        wait_n(H);
        SCL = 1'b1;
        wait_n(H);
        rv = '{7'h2B, 8'h56, 2, 32'h98760000, 1'b1, 4'b0011, 16'h9876, 1};
        run_write(rv);
        model_wr = 16'h9876;

        // Random writes and reads against the transaction-level model
        for (int it = 0; it < 30; it++) begin
            if (it % 2 == 0) begin
                rv.tgt   = 7'($urandom);
                rv.ab    = {($urandom_range(0, 1) == 1) ? rv.tgt : 7'($urandom), 1'b0};
                rv.n     = $urandom_range(0, 3);
                rv.bytes = $urandom;
                rv.e_aack = model_hit(rv.tgt, rv.ab);
                rv.e_back = '0;
                for (int k = 0; k < rv.n; k++) rv.e_back[k] = rv.e_aack && (k < NB);
                if (rv.e_aack && rv.n >= NB) begin
                    model_wr = rv.bytes[31:16];
                    rv.e_stb = 1;
                end else begin
                    rv.e_stb = 0;
                end
                rv.e_wr = model_wr;
                run_write(rv);
            end else begin
                I2C_ADDR = 7'($urandom_range(1, 127));
                rsnap    = 16'($urandom);
                RD_DATA  = rsnap;
                nb       = $urandom_range(1, NB);
                do_start();
                wr_byte({I2C_ADDR, 1'b1}, ack);
                chk("rnd_rd_addr_ack", ack, 1);
                RD_DATA = 16'($urandom);
                for (int k = 0; k < nb; k++) begin
                    mack = (k == nb - 1) ? 1'($urandom) : 1'b0;
                    rd_byte(mack, got);
                    chk("rnd_rd_byte", got, rsnap[15-8*k -: 8]);
                end
                do_stop();
                chk("rnd_rd_wr_data_kept", WR_DATA, model_wr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
